trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_pkg.sv | 37 +++
 rtl/trap_int_sel.sv | 33 +++
 rtl/trap_ctrl.sv | 151 +++++++++++++++
 tb/tb_trap_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Holds state encoding, interrupt causes and mtvec mode helpers.
package trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRAP     = 2'd1,
    S_MRET     = 2'd2,
    S_REDIRECT = 2'd3
  } trap_state_e;

  localparam logic [1:0] ST_IDLE     = S_IDLE;
  localparam logic [1:0] ST_TRAP     = S_TRAP;
  localparam logic [1:0] ST_MRET     = S_MRET;
  localparam logic [1:0] ST_REDIRECT = S_REDIRECT;

  localparam logic [30:0] CAUSE_MSI = 31'd3;
  localparam logic [30:0] CAUSE_MTI = 31'd7;
  localparam logic [30:0] CAUSE_MEI = 31'd11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // Vectored offset applies to interrupts only; wraps at 32 bits.
  function automatic logic [31:0] trap_target(
    input logic [31:0] mtvec,
    input logic        is_int,
    input logic [30:0] cause
  );
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (is_int && mtvec[1:0] == MTVEC_VECTORED)
      return base + {cause[29:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_int_sel.sv
// Combinational machine interrupt selector.
// Picks the winning pending-and-enabled interrupt: MEI > MSI > MTI.
import trap_pkg::*;

module trap_int_sel (
  input  logic        mip_msip,
  input  logic        mip_mtip,
  input  logic        mip_meip,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  output logic        int_valid,
  output logic [30:0] int_cause
);

  logic mei, msi, mti;

  assign mei = mip_meip & mie_meie;
  assign msi = mip_msip & mie_msie;
  assign mti = mip_mtip & mie_mtie;

  always_comb begin
    int_valid = mei | msi | mti;
    int_cause = '0;
    priority case (1'b1)
      mei:     int_cause = CAUSE_MEI;
      msi:     int_cause = CAUSE_MSI;
      mti:     int_cause = CAUSE_MTI;
      default: int_cause = '0;
    endcase
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: captures the event, strobes the
// CSR update for one cycle, then holds a fetch redirect until acked.
import trap_pkg::*;

module trap_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [30:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_val,
  input  logic        mret_valid,
  input  logic        int_ok,
  input  logic [31:0] next_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mstatus_mie,
  input  logic        mstatus_mpie,
  input  logic        mip_msip,
  input  logic        mip_mtip,
  input  logic        mip_meip,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  output logic        trap_wr_en,
  output logic        trap_mie,
  output logic        trap_mpie,
  output logic        trap_int,
  output logic [30:0] trap_cause,
  output logic [31:0] trap_pc_in,
  output logic [31:0] trap_val,
  output logic        mret_wr_en,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        flush,
  output logic        busy
);

  logic [1:0]  state;
  logic        int_valid;
  logic [30:0] int_cause;
  logic        take_exc, take_int, take_mret;

  logic        int_q;
  logic        mpie_q;
  logic [30:0] cause_q;
  logic [31:0] pc_q;
  logic [31:0] val_q;
  logic [31:0] target_q;

  trap_int_sel u_int_sel (
    .mip_msip  (mip_msip),
    .mip_mtip  (mip_mtip),
    .mip_meip  (mip_meip),
    .mie_msie  (mie_msie),
    .mie_mtie  (mie_mtie),
    .mie_meie  (mie_meie),
    .int_valid (int_valid),
    .int_cause (int_cause)
  );

  // Events are only sampled in IDLE; the pipeline holds them otherwise.
  assign take_exc  = (state == ST_IDLE) & exc_valid;
  assign take_int  = (state == ST_IDLE) & ~exc_valid
                   & int_ok & mstatus_mie & int_valid;
  assign take_mret = (state == ST_IDLE) & ~exc_valid
                   & ~(int_ok & mstatus_mie & int_valid)
                   & mret_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      int_q    <= 1'b0;
      mpie_q   <= 1'b0;
      cause_q  <= '0;
      pc_q     <= '0;
      val_q    <= '0;
      target_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take_exc) begin
            state    <= ST_TRAP;
            int_q    <= 1'b0;
            mpie_q   <= mstatus_mie;
            cause_q  <= exc_cause;
            pc_q     <= exc_pc;
            val_q    <= exc_val;
            target_q <= trap_target(mtvec, 1'b0, exc_cause);
          end else if (take_int) begin
            state    <= ST_TRAP;
            int_q    <= 1'b1;
            mpie_q   <= 1'b1;
            cause_q  <= int_cause;
            pc_q     <= next_pc;
            val_q    <= '0;
            target_q <= trap_target(mtvec, 1'b1, int_cause);
          end else if (take_mret) begin
            state    <= ST_MRET;
            target_q <= mepc;
          end
        end
        ST_TRAP:     state <= ST_REDIRECT;
        ST_MRET:     state <= ST_REDIRECT;
        ST_REDIRECT: if (redirect_ack) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    trap_wr_en     = 1'b0;
    mret_wr_en     = 1'b0;
    trap_mie       = 1'b0;
    trap_mpie      = 1'b0;
    trap_int       = 1'b0;
    trap_cause     = '0;
    trap_pc_in     = '0;
    trap_val       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    unique case (state)
      ST_TRAP: begin
        trap_wr_en = 1'b1;
        trap_mpie  = mpie_q;
        trap_int   = int_q;
        trap_cause = cause_q;
        trap_pc_in = pc_q;
        trap_val   = val_q;
        flush      = 1'b1;
      end
      ST_MRET: begin
        mret_wr_en = 1'b1;
        trap_mie   = mstatus_mpie;
        trap_mpie  = 1'b1;
        flush      = 1'b1;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        flush          = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus random
// events compared against a priority-rule reference model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [30:0] exc_cause;
  logic [31:0] exc_pc, exc_val;
  logic        mret_valid, int_ok;
  logic [31:0] next_pc, mtvec, mepc;
  logic        mstatus_mie, mstatus_mpie;
  logic        mip_msip, mip_mtip, mip_meip;
  logic        mie_msie, mie_mtie, mie_meie;
  logic        trap_wr_en, trap_mie, trap_mpie, trap_int;
  logic [30:0] trap_cause;
  logic [31:0] trap_pc_in, trap_val;
  logic        mret_wr_en, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack, flush, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_val(exc_val),
    .mret_valid(mret_valid), .int_ok(int_ok),
    .next_pc(next_pc), .mtvec(mtvec), .mepc(mepc),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mip_msip(mip_msip), .mip_mtip(mip_mtip), .mip_meip(mip_meip),
    .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .trap_wr_en(trap_wr_en), .trap_mie(trap_mie),
    .trap_mpie(trap_mpie), .trap_int(trap_int),
    .trap_cause(trap_cause), .trap_pc_in(trap_pc_in),
    .trap_val(trap_val), .mret_wr_en(mret_wr_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .flush(flush), .busy(busy)
  );

  typedef struct {
    int          kind;   // 0 none, 1 trap, 2 mret
    logic        is_int;
    logic [30:0] cause;
    logic [31:0] pc;
    logic [31:0] val;
    logic        mpie;
    logic [31:0] target;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exc_valid = 0; exc_cause = '0; exc_pc = '0; exc_val = '0;
    mret_valid = 0; int_ok = 0; next_pc = '0; mtvec = '0;
    mepc = '0; mstatus_mie = 0; mstatus_mpie = 0;
    mip_msip = 0; mip_mtip = 0; mip_meip = 0;
    mie_msie = 0; mie_mtie = 0; mie_meie = 0;
    redirect_ack = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".trap_wr_en"}, {31'b0, trap_wr_en}, 0);
    chk({tag, ".mret_wr_en"}, {31'b0, mret_wr_en}, 0);
    chk({tag, ".trap_mie"}, {31'b0, trap_mie}, 0);
    chk({tag, ".trap_mpie"}, {31'b0, trap_mpie}, 0);
    chk({tag, ".trap_int"}, {31'b0, trap_int}, 0);
    chk({tag, ".trap_cause"}, {1'b0, trap_cause}, 0);
    chk({tag, ".trap_pc_in"}, trap_pc_in, 0);
    chk({tag, ".trap_val"}, trap_val, 0);
    chk({tag, ".redirect_valid"}, {31'b0, redirect_valid}, 0);
    chk({tag, ".redirect_pc"}, redirect_pc, 0);
    chk({tag, ".flush"}, {31'b0, flush}, 0);
    chk({tag, ".busy"}, {31'b0, busy}, 0);
  endtask

  function automatic logic pending(input int c);
    case (c)
      11:      return mip_meip & mie_meie;
      3:       return mip_msip & mie_msie;
      7:       return mip_mtip & mie_mtie;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: exception > interrupt (MEI, MSI, MTI) > MRET.
  function automatic exp_t predict();
    exp_t e;
    int prio[3];
    logic [31:0] base;
    prio = '{11, 3, 7};
    base = mtvec & 32'hFFFF_FFFC;
    e = '{0, 1'b0, 31'd0, 32'd0, 32'd0, 1'b0, 32'd0};
    if (exc_valid) begin
      e = '{1, 1'b0, exc_cause, exc_pc, exc_val, mstatus_mie, base};
    end else begin
      if (int_ok && mstatus_mie) begin
        for (int i = 0; i < 3; i++) begin
          if (e.kind == 0 && pending(prio[i])) begin
            e.kind   = 1;
            e.is_int = 1'b1;
            e.cause  = 31'(prio[i]);
            e.pc     = next_pc;
            e.val    = 0;
            e.mpie   = 1'b1;
            e.target = (mtvec[1:0] == 2'd1)
                     ? base + 32'(4 * prio[i]) : base;
          end
        end
      end
      if (e.kind == 0 && mret_valid) begin
        e.kind   = 2;
        e.target = mepc;
      end
    end
    return e;
  endfunction

  task automatic do_event(input int ack_dly);
    exp_t e;
    logic mpie_in;
    e = predict();
    mpie_in = mstatus_mpie;
    step();
    exc_valid = 0; mret_valid = 0; int_ok = 0;
    if (e.kind == 0) begin
      chk("idle.busy", {31'b0, busy}, 0);
      chk("idle.trap_wr_en", {31'b0, trap_wr_en}, 0);
      chk("idle.mret_wr_en", {31'b0, mret_wr_en}, 0);
      chk("idle.redirect_valid", {31'b0, redirect_valid}, 0);
      return;
    end
    chk("ev.busy", {31'b0, busy}, 1);
    chk("ev.flush", {31'b0, flush}, 1);
    if (e.kind == 1) begin
      chk("trap.wr_en", {31'b0, trap_wr_en}, 1);
      chk("trap.mret_wr_en", {31'b0, mret_wr_en}, 0);
      chk("trap.int", {31'b0, trap_int}, {31'b0, e.is_int});
      chk("trap.cause", {1'b0, trap_cause}, {1'b0, e.cause});
      chk("trap.pc_in", trap_pc_in, e.pc);
      chk("trap.val", trap_val, e.val);
      chk("trap.mpie", {31'b0, trap_mpie}, {31'b0, e.mpie});
      chk("trap.mie", {31'b0, trap_mie}, 0);
    end else begin
      chk("mret.wr_en", {31'b0, mret_wr_en}, 1);
      chk("mret.trap_wr_en", {31'b0, trap_wr_en}, 0);
      chk("mret.mie", {31'b0, trap_mie}, {31'b0, mpie_in});
      chk("mret.mpie", {31'b0, trap_mpie}, 1);
    end
    step();
    chk("rd.trap_wr_en", {31'b0, trap_wr_en}, 0);
    chk("rd.mret_wr_en", {31'b0, mret_wr_en}, 0);
    chk("rd.valid", {31'b0, redirect_valid}, 1);
    chk("rd.pc", redirect_pc, e.target);
    chk("rd.trap_cause", {1'b0, trap_cause}, 0);
    for (int i = 0; i < ack_dly; i++) begin
      exc_valid = 1; mret_valid = 1; int_ok = 1; mstatus_mie = 1;
      mip_meip = 1; mie_meie = 1;
      mtvec = $urandom; mepc = $urandom;
      step();
      chk("hold.valid", {31'b0, redirect_valid}, 1);
      chk("hold.pc", redirect_pc, e.target);
      chk("hold.busy", {31'b0, busy}, 1);
      chk("hold.trap_wr_en", {31'b0, trap_wr_en}, 0);
      chk("hold.mret_wr_en", {31'b0, mret_wr_en}, 0);
    end
    redirect_ack = 1;
    step();
    redirect_ack = 0;
    exc_valid = 0; mret_valid = 0; int_ok = 0;
    chk("ack.busy", {31'b0, busy}, 0);
    chk("ack.valid", {31'b0, redirect_valid}, 0);
    chk("ack.flush", {31'b0, flush}, 0);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    step();
    step();
    chk_zero("reset");
    reset = 0;
    step();
    chk_zero("idle_after_reset");

    // Exception, direct mtvec
    clear_inputs();
    exc_valid = 1; exc_cause = 31'd2; exc_pc = 32'h8AB4;
    exc_val = 32'hFFEEDD11; mstatus_mie = 1; mtvec = 32'h4;
    do_event(0);

    // Vectored interrupt, all sources pending
    clear_inputs();
    mtvec = 32'h101; mstatus_mie = 1; int_ok = 1; next_pc = 32'h8A9C;
    mip_msip = 1; mip_mtip = 1; mip_meip = 1;
    mie_msie = 1; mie_mtie = 1; mie_meie = 1;
    do_event(1);

    // Exception beats MRET and timer interrupt
    clear_inputs();
    exc_valid = 1; exc_cause = 31'd5; exc_pc = 32'h1000;
    mret_valid = 1; int_ok = 1; mstatus_mie = 1;
    mip_mtip = 1; mie_mtie = 1; mtvec = 32'h201;
    do_event(0);

    // MRET
    clear_inputs();
    mret_valid = 1; mepc = 32'h8A9C; mstatus_mpie = 1;
    do_event(2);

    // Long ack wait with ignored exception
    clear_inputs();
    exc_valid = 1; exc_cause = 31'd11; exc_pc = 32'h40;
    mtvec = 32'h8000_0001;
    do_event(5);

    // Reset while in TRAP
    clear_inputs();
    exc_valid = 1; exc_cause = 31'd3; exc_pc = 32'h77;
    mtvec = 32'h300;
    step();
    exc_valid = 0;
    chk("pre_rst_trap.wr_en", {31'b0, trap_wr_en}, 1);
    reset = 1;
    step();
    chk_zero("rst_in_trap");
    reset = 0;
    step();
    chk_zero("after_rst_trap");

    // Reset while in REDIRECT
    clear_inputs();
    mret_valid = 1; mepc = 32'h1234;
    step();
    mret_valid = 0;
    step();
    chk("pre_rst_rd.valid", {31'b0, redirect_valid}, 1);
    reset = 1;
    step();
    chk_zero("rst_in_redirect");
    reset = 0;
    step();
    chk_zero("after_rst_redirect");

    // Random events
    for (int n = 0; n < 60; n++) begin
      clear_inputs();
      exc_valid    = ($urandom % 4) == 0;
      exc_cause    = 31'($urandom % 16);
      exc_pc       = $urandom;
      exc_val      = $urandom;
      mret_valid   = ($urandom % 3) == 0;
      int_ok       = $urandom % 2;
      next_pc      = $urandom;
      mtvec        = $urandom;
      mepc         = $urandom;
      mstatus_mie  = $urandom % 2;
      mstatus_mpie = $urandom % 2;
      mip_msip = $urandom % 2; mip_mtip = $urandom % 2;
      mip_meip = $urandom % 2;
      mie_msie = $urandom % 2; mie_mtie = $urandom % 2;
      mie_meie = $urandom % 2;
      do_event(int'($urandom % 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
